// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO and transmit handshake sequencer feeding the uart transmitter (option: UART_TXQ_OVF_COUNT_EN)
module uart_tx_queue #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  uart_transmit,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_is_transmitting,
    output logic                  busy
`ifdef UART_TXQ_OVF_COUNT_EN
    ,
    output logic [7:0]            ovf_count
`endif
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        RETRY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_nxt;
    logic                  transmit_nxt;
    logic                  pop;
    logic                  push;
    logic                  drop;

    // Occupancy flags come straight from the registered pointers
    always_comb begin
        count = wr_ptr - rd_ptr;
        full  = (count == PW'(DEPTH));
        empty = (count == '0);
        busy  = (state != IDLE);
    end

    // A flush swallows any same-cycle write without flagging it as an overflow
    always_comb begin
        push = wr_en && !full && !flush;
        drop = wr_en && full && !flush;
    end

    // Handshake sequencer: next state, pop request and transmit/timer updates
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        transmit_nxt = uart_transmit;
        timer_nxt    = timer;
        case (state)
            IDLE: begin
                if (!empty && !uart_is_transmitting && !flush) begin
                    pop          = 1'b1;
                    transmit_nxt = 1'b1;
                    timer_nxt    = '0;
                    state_nxt    = ACK;
                end
            end
            ACK: begin
                if (uart_is_transmitting) begin
                    transmit_nxt = 1'b0;
                    state_nxt    = DONE;
                end else if (timer == TW'(ACK_TIMEOUT)) begin
                    transmit_nxt = 1'b0;
                    state_nxt    = RETRY;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            RETRY: begin
                // Transmit was low for exactly this cycle; re-offer the same byte
                transmit_nxt = 1'b1;
                timer_nxt    = '0;
                state_nxt    = ACK;
            end
            DONE: begin
                if (!uart_is_transmitting) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                transmit_nxt = 1'b0;
                state_nxt    = IDLE;
            end
        endcase
    end

    // State, transmit strobe and ack timer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            uart_transmit <= 1'b0;
            timer         <= '0;
        end else begin
            state         <= state_nxt;
            uart_transmit <= transmit_nxt;
            timer         <= timer_nxt;
        end
    end

    // Byte storage has no reset; only locations between the pointers are ever read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Pointers, output byte latch and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            uart_tx_byte <= 8'h00;
            overflow     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                uart_tx_byte <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef UART_TXQ_OVF_COUNT_EN
    // Saturating count of dropped pushes, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count <= 8'h00;
        end else if (drop && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'h01;
        end
    end
`endif

endmodule
